// File: rtl/fft_mem_pkg.sv
// Shared definitions for the FFT ping-pong input memory: sample formats,
// loader FSM encoding and default frame size.
package fft_mem_pkg;

    localparam logic FMT_FP4 = 1'b0;
    localparam logic FMT_FP8 = 1'b1;

    localparam int DEFAULT_N = 1024;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_SWAP = 1'b1
    } state_t;

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream handshake into the FFT input loader.
interface fft_input_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/fft_input_loader_bit_reverse.sv
// Combinational bit reversal of a WIDTH-bit index.
module bit_reverse #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_out
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_rev
        assign o_out[g] = i_in[WIDTH-1-g];
    end

endmodule

// File: rtl/fft_input_loader.sv
// Packs fp8/fp4 complex samples into the idle bank of a ping-pong FFT input
// memory. Define FFT_LOADER_BITREV_EN for bit-reversed write addresses.
module fft_input_loader
    import fft_mem_pkg::*;
#(
    parameter int N          = DEFAULT_N,
    parameter int ADDR_WIDTH = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  format_mode,
    fft_input_loader_if.slave     in_if,
    input  logic                  consumer_ready,
    output logic                  wr_en_1,
    output logic [ADDR_WIDTH-1:0] wr_addr_1,
    output logic [15:0]           wr_data_1,
    output logic                  wr_format,
    output logic                  bank_sel,
    output logic                  frame_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_FP8 = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_FP4 = ADDR_WIDTH'(N / 2 - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [7:0]            r_hold;
    logic                  r_pending;
    logic                  r_fmt;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [15:0]           r_wr_data;
    logic                  r_wr_format;
    logic                  r_bank_sel;
    logic                  r_frame_done;

    logic                  w_accept;
    logic                  w_frame_start;
    logic                  w_fmt;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign in_if.in_ready = (r_state == ST_LOAD);
    assign w_accept       = in_if.in_valid && in_if.in_ready;

    // The frame format is only open to change before the first half-word lands.
    assign w_frame_start = (r_cnt == '0) && !r_pending;
    assign w_fmt         = w_frame_start ? format_mode : r_fmt;
    assign w_last        = (w_fmt == FMT_FP8) ? (r_cnt == LAST_FP8) : (r_cnt == LAST_FP4);
    assign w_cnt_next    = w_last ? '0 : r_cnt + 1'b1;

`ifdef FFT_LOADER_BITREV_EN
    logic [ADDR_WIDTH-1:0] w_rev_full;
    logic [ADDR_WIDTH-2:0] w_rev_half;

    bit_reverse #(.WIDTH(ADDR_WIDTH)) u_rev_full (
        .i_in  (r_cnt),
        .o_out (w_rev_full)
    );

    bit_reverse #(.WIDTH(ADDR_WIDTH-1)) u_rev_half (
        .i_in  (r_cnt[ADDR_WIDTH-2:0]),
        .o_out (w_rev_half)
    );

    // fp4 frames occupy only the lower half of the bank.
    assign w_addr = (w_fmt == FMT_FP8) ? w_rev_full : {1'b0, w_rev_half};
`else
    assign w_addr = r_cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_LOAD;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_pending    <= 1'b0;
            r_fmt        <= FMT_FP4;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_format  <= 1'b0;
            r_bank_sel   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_fmt <= w_fmt;
                        if ((w_fmt == FMT_FP4) && !r_pending) begin
                            r_hold    <= in_if.in_data[7:0];
                            r_pending <= 1'b1;
                        end else begin
                            r_wr_en     <= 1'b1;
                            r_wr_addr   <= w_addr;
                            r_wr_data   <= (w_fmt == FMT_FP8) ? in_if.in_data
                                                              : {r_hold, in_if.in_data[7:0]};
                            r_wr_format <= w_fmt;
                            r_pending   <= 1'b0;
                            r_cnt       <= w_cnt_next;
                            if (w_last) begin
                                r_state <= ST_SWAP;
                            end
                        end
                    end
                end
                // Swap one edge after the final write so it lands in the old fill bank.
                ST_SWAP: begin
                    if (consumer_ready) begin
                        r_bank_sel   <= ~r_bank_sel;
                        r_frame_done <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= ST_LOAD;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign wr_en_1    = r_wr_en;
    assign wr_addr_1  = r_wr_addr;
    assign wr_data_1  = r_wr_data;
    assign wr_format  = r_wr_format;
    assign bank_sel   = r_bank_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with N = 8.
module tb_fft_input_loader;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          format_mode;
    logic          consumer_ready;
    logic          wr_en_1;
    logic [AW-1:0] wr_addr_1;
    logic [15:0]   wr_data_1;
    logic          wr_format;
    logic          bank_sel;
    logic          frame_done;

    int n_pass;
    int n_total;

    fft_input_loader_if in_if ();

    fft_input_loader #(.N(N), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .format_mode    (format_mode),
        .in_if          (in_if),
        .consumer_ready (consumer_ready),
        .wr_en_1        (wr_en_1),
        .wr_addr_1      (wr_addr_1),
        .wr_data_1      (wr_data_1),
        .wr_format      (wr_format),
        .bank_sel       (bank_sel),
        .frame_done     (frame_done)
    );

`ifdef FFT_LOADER_BITREV_EN
    logic [AW-1:0] exp8 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [AW-1:0] exp4 [4] = '{3'd0, 3'd2, 3'd1, 3'd3};
`else
    logic [AW-1:0] exp8 [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [AW-1:0] exp4 [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
`endif

    logic [7:0]  lo4   [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [15:0] word4 [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst            = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        format_mode    = 1'b0;
        consumer_ready = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({wr_en_1, wr_addr_1, wr_data_1, wr_format, bank_sel, frame_done} !== '0)
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h fmt=%b bank=%b done=%b, want all 0",
                     wr_en_1, wr_addr_1, wr_data_1, wr_format, bank_sel, frame_done);
        else n_pass++;
        rst = 1'b1;
        n_total++;
        if (in_if.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b want 1", in_if.in_ready);
        else n_pass++;
    endtask

    task automatic test_fp8_frame;
        logic [15:0] d;
        format_mode    = 1'b1;
        consumer_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d              = {8'(i + 1), 8'(i)};
            in_if.in_valid = 1'b1;
            in_if.in_data  = d;
            tick();
            n_total++;
            if ({wr_en_1, wr_addr_1, wr_data_1, wr_format} !== {1'b1, exp8[i], d, 1'b1})
                $display("FAIL fp8_write[%0d]: got en=%b addr=%0d data=%h fmt=%b want en=1 addr=%0d data=%h fmt=1",
                         i, wr_en_1, wr_addr_1, wr_data_1, wr_format, exp8[i], d);
            else n_pass++;
        end
        in_if.in_valid = 1'b0;
        n_total++;
        if ({frame_done, bank_sel, in_if.in_ready} !== 3'b000)
            $display("FAIL fp8_last_write_no_swap: got done=%b bank=%b rdy=%b want 0 0 0",
                     frame_done, bank_sel, in_if.in_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({frame_done, bank_sel, in_if.in_ready, wr_en_1} !== 4'b1110)
            $display("FAIL fp8_swap: got done=%b bank=%b rdy=%b en=%b want 1 1 1 0",
                     frame_done, bank_sel, in_if.in_ready, wr_en_1);
        else n_pass++;
        tick();
        n_total++;
        if ({frame_done, bank_sel} !== 2'b01)
            $display("FAIL fp8_done_single_pulse: got done=%b bank=%b want 0 1", frame_done, bank_sel);
        else n_pass++;
    endtask

    task automatic test_fp4_backpressure;
        format_mode    = 1'b0;
        consumer_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_data  = {8'hC3, lo4[i]};
            tick();
            n_total++;
            if (i % 2 == 0) begin
                if (wr_en_1 !== 1'b0)
                    $display("FAIL fp4_first_half[%0d]: got en=%b want 0", i, wr_en_1);
                else n_pass++;
            end else begin
                if ({wr_en_1, wr_addr_1, wr_data_1, wr_format} !== {1'b1, exp4[i/2], word4[i/2], 1'b0})
                    $display("FAIL fp4_write[%0d]: got en=%b addr=%0d data=%h fmt=%b want en=1 addr=%0d data=%h fmt=0",
                             i / 2, wr_en_1, wr_addr_1, wr_data_1, wr_format, exp4[i/2], word4[i/2]);
                else n_pass++;
            end
        end
        in_if.in_data = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++;
            if ({in_if.in_ready, bank_sel, frame_done, wr_en_1} !== 4'b0100)
                $display("FAIL stall[%0d]: got rdy=%b bank=%b done=%b en=%b want 0 1 0 0",
                         c, in_if.in_ready, bank_sel, frame_done, wr_en_1);
            else n_pass++;
        end
        consumer_ready = 1'b1;
        tick();
        in_if.in_valid = 1'b0;
        n_total++;
        if ({bank_sel, frame_done, in_if.in_ready} !== 3'b011)
            $display("FAIL stall_release: got bank=%b done=%b rdy=%b want 0 1 1",
                     bank_sel, frame_done, in_if.in_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({frame_done, wr_en_1, bank_sel} !== 3'b000)
            $display("FAIL stall_after: got done=%b en=%b bank=%b want 0 0 0", frame_done, wr_en_1, bank_sel);
        else n_pass++;
    endtask

    task automatic test_format_midframe;
        logic [15:0] d;
        format_mode    = 1'b0;
        consumer_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) format_mode = 1'b1;
            in_if.in_valid = 1'b1;
            in_if.in_data  = {8'hFF, 8'(i * 17)};
            tick();
            n_total++;
            if (i % 2 == 0) begin
                if (wr_en_1 !== 1'b0)
                    $display("FAIL midfmt_half[%0d]: got en=%b want 0", i, wr_en_1);
                else n_pass++;
            end else begin
                if ({wr_en_1, wr_format} !== 2'b10)
                    $display("FAIL midfmt_write[%0d]: got en=%b fmt=%b want en=1 fmt=0", i, wr_en_1, wr_format);
                else n_pass++;
            end
        end
        in_if.in_valid = 1'b0;
        tick();
        n_total++;
        if ({frame_done, bank_sel} !== 2'b11)
            $display("FAIL midfmt_swap: got done=%b bank=%b want 1 1", frame_done, bank_sel);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            d              = {8'(i), ~8'(i)};
            in_if.in_valid = 1'b1;
            in_if.in_data  = d;
            tick();
            n_total++;
            if ({wr_en_1, wr_addr_1, wr_data_1, wr_format} !== {1'b1, exp8[i], d, 1'b1})
                $display("FAIL nextfrm_fp8[%0d]: got en=%b addr=%0d data=%h fmt=%b want en=1 addr=%0d data=%h fmt=1",
                         i, wr_en_1, wr_addr_1, wr_data_1, wr_format, exp8[i], d);
            else n_pass++;
        end
        in_if.in_valid = 1'b0;
        tick();
        n_total++;
        if ({frame_done, bank_sel} !== 2'b10)
            $display("FAIL nextfrm_swap: got done=%b bank=%b want 1 0", frame_done, bank_sel);
        else n_pass++;
    endtask

    task automatic test_reset_midframe;
        logic [15:0] d;
        format_mode    = 1'b1;
        consumer_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_if.in_valid = 1'b1;
            in_if.in_data  = 16'hA1B2 + 16'(i);
            tick();
        end
        in_if.in_valid = 1'b0;
        n_total++;
        if ({wr_en_1, wr_addr_1, wr_format} !== {1'b1, exp8[2], 1'b1})
            $display("FAIL prereset_write: got en=%b addr=%0d fmt=%b want 1 %0d 1",
                     wr_en_1, wr_addr_1, wr_format, exp8[2]);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({wr_en_1, wr_addr_1, wr_data_1, wr_format, frame_done, bank_sel} !== '0)
            $display("FAIL async_reset_clear: got en=%b addr=%0d data=%h fmt=%b done=%b bank=%b want all 0",
                     wr_en_1, wr_addr_1, wr_data_1, wr_format, frame_done, bank_sel);
        else n_pass++;
        tick();
        rst = 1'b1;
        n_total++;
        if (in_if.in_ready !== 1'b1)
            $display("FAIL postreset_ready: got %b want 1", in_if.in_ready);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            d              = {8'(i + 1), 8'(i)};
            in_if.in_valid = 1'b1;
            in_if.in_data  = d;
            tick();
            n_total++;
            if ({wr_en_1, wr_addr_1, wr_data_1, wr_format, frame_done, bank_sel} !==
                {1'b1, exp8[i], d, 1'b1, 1'b0, 1'b0})
                $display("FAIL postreset_write[%0d]: got en=%b addr=%0d data=%h fmt=%b done=%b bank=%b want 1 %0d %h 1 0 0",
                         i, wr_en_1, wr_addr_1, wr_data_1, wr_format, frame_done, bank_sel, exp8[i], d);
            else n_pass++;
        end
        in_if.in_valid = 1'b0;
        tick();
        n_total++;
        if ({frame_done, bank_sel} !== 2'b11)
            $display("FAIL postreset_swap: got done=%b bank=%b want 1 1", frame_done, bank_sel);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_fp8_frame();
        test_fp4_backpressure();
        test_format_midframe();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter N, default 1024, meaning complex samples per frame (power of two, >= 4).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(N), meaning memory word address width.
REQ-003 SHALL use one clock, with asynchronous active-low reset: port clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port format_mode, input, 1 bit: 0 = fp4, 1 = fp8; sampled at frame start only.
REQ-006 SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, 16 bits). For fp8, in_data is real[15:8], imag[7:0]. For fp4, in_data is real[7:4], imag[3:0], and [15:8] is ignored.
REQ-007 SHALL have port consumer_ready, input, 1 bit: downstream FFT core has released the bank it reads.
REQ-008 SHALL have ports wr_en_1 (output, 1 bit), wr_addr_1 (output, ADDR_WIDTH bits), wr_data_1 (output, 16 bits) and wr_format (output, 1 bit). These drive the ping-pong memory write port.
REQ-009 SHALL have port bank_sel, output, 1 bit: memory read-bank select; the loader always fills ~bank_sel.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a filled bank is handed over.

Function
REQ-011 SHALL implement FSM states LOAD and SWAP. in_ready = 1 only in LOAD.
REQ-012 SHALL accept a sample on any clk edge with in_valid && in_ready.
REQ-013 SHALL latch format_mode into the frame format register only when word count = 0 and no fp4 half-word is pending.
REQ-014 fp8: each accepted sample SHALL produce one write with wr_data_1 = in_data. Frame length is N words.
REQ-015 fp4, first sample of a pair: SHALL store in_data[7:0] in a holding register and SHALL NOT write.
REQ-016 fp4, second sample of a pair: SHALL write {hold, in_data[7:0]}, giving real0 imag0 real1 imag1. Frame length is N/2 words.
REQ-017 wr_en_1, wr_addr_1, wr_data_1 and wr_format SHALL be registered, asserting exactly 1 cycle after the accepting edge. wr_format SHALL equal the latched frame format.
REQ-018 wr_addr_1 SHALL be the word count, bit-reversed per REQ-029/030. The word count wraps to 0 at the end of a frame.
REQ-019 On the accepting edge of the last word of a frame, the FSM SHALL move to SHALL move to SWAP.
REQ-020 In SWAP with consumer_ready = 1, the FSM SHALL toggle bank_sel, pulse frame_done for one cycle and return to LOAD with count 0. Both outputs SHALL change on the same edge.
REQ-021 In SWAP with consumer_ready = 0, the FSM SHALL hold with in_ready = 0, with no write and no toggle.
REQ-022 The toggle SHALL occur no earlier than the edge after the final write's wr_en_1, so the last write lands in the old fill bank.
REQ-023 in_valid while in_ready = 0 SHALL be ignored, with no state change.

Reset
REQ-024 On rst low, asynchronously: state = LOAD; bank_sel = 0, so the first frame fills bank1.
REQ-025 On rst low, asynchronously: word count = 0, hold cleared, pending flag = 0 and frame format = 0.
REQ-026 On rst low, asynchronously: wr_en_1 = 0, wr_addr_1 = 0, wr_data_1 = 0, wr_format = 0 and frame_done = 0.
REQ-027 A partial frame interrupted by reset SHALL be discarded, with no frame_done.
REQ-028 After reset deassertion, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-029 With macro FFT_LOADER_BITREV_EN defined, wr_addr_1 SHALL be the bit-reverse of the word count. fp8 reverses ADDR_WIDTH bits; fp4 reverses the low ADDR_WIDTH-1 bits, with the MSB = 0.
REQ-030 Without FFT_LOADER_BITREV_EN, wr_addr_1 SHALL equal the word count (natural order), and no reversal logic SHALL be present.

Structure
REQ-031 Shared package fft_mem_pkg SHALL hold the following: FMT_FP4 = 1'b0, FMT_FP8 = 1'b1, the FSM state encoding and the default N.
REQ-032 A sub-module bit_reverse SHALL be used: combinational, parameter WIDTH, instantiated only under FFT_LOADER_BITREV_EN.

Verification (N = 8, FFT_LOADER_BITREV_EN defined unless stated)
REQ-033 fp8, 8 back-to-back samples 0x0100..0x0807 with consumer_ready = 1 SHALL produce the following:
- writes to addresses 0,4,2,6,1,5,3,7 with matching data, one cycle after each accept;
- frame_done pulse and bank_sel 0->1 one cycle after the last write.
REQ-034 fp4, samples with low bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 SHALL produce the following:
- 4 writes 0x1234@0, 0x5678@2, 0x9ABC@1, 0xDEF0@3, all with wr_format = 0;
- frame_done after the 8th sample.
REQ-035 Second frame with consumer_ready = 0 for 5 cycles after completion: in_ready SHALL stay 0 and bank_sel SHALL stay 1 for 5 cycles. On the consumer_ready rise, bank_sel SHALL go 1->0 and frame_done SHALL pulse once.
REQ-036 format_mode toggled 0->1 mid-frame SHALL leave wr_format = 0 for the remaining words. The next frame SHALL use fp8.
REQ-037 rst pulsed low after 3 fp8 samples SHALL clear all outputs immediately. The following 8 samples SHALL write addresses 0,4,2,... to bank1 with no frame_done before the 8th.
REQ-038 Without FFT_LOADER_BITREV_EN, the REQ-033 stimulus SHALL write to addresses 0..7 in order.
